reaction_timer_mp: RTL

Parametrised multi-player reaction-timer core. After a START request it waits a pseudo-random number of millisecond ticks, lights the go LED, and times each player's button press in BCD milliseconds. It flags false starts, picks the round winner and keeps a best-time register. It sits between the debounced KEY/SW inputs and the per-digit seven-segment decoders in the top level, and it replaces the separate FSM, down-counter, BCD-counter and high-score blocks.

---
 rtl/reaction_timer_mp.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: random go delay, BCD ms timing per player,
// false-start detection, round winner and best-time tracking.
module reaction_timer_mp #(
   parameter int PLAYERS   = 2,
   parameter int DIGITS    = 4,
   parameter int TICK_DIV  = 50000,
   parameter int MIN_DELAY = 1000
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          START,
   input  logic [PLAYERS-1:0]            BTN,
   output logic                          LED,
   output logic [4*DIGITS*PLAYERS-1:0]   TIME_BCD,
   output logic [PLAYERS-1:0]            FOUL,
   output logic [1:0]                    WINNER,
   output logic                          WIN_VALID,
   output logic [4*DIGITS-1:0]           BEST_BCD,
   output logic [1:0]                    BEST_ID,
   output logic                          DONE
);

   localparam int TW    = 4 * DIGITS;
   localparam int CNT_W = $clog2(TICK_DIV);
   localparam int DLY_W = $clog2(MIN_DELAY + 2048);
   localparam logic [TW-1:0] ALL9 = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ARMED,
      S_RESULT
   } state_t;

   state_t state, state_n;

   logic [10:0]        lfsr;
   logic               start_q;
   logic [PLAYERS-1:0] btn_q;
   logic               start_rise;
   logic [PLAYERS-1:0] btn_rise;
   logic [CNT_W-1:0]   tick_cnt;
   logic               tick;
   logic [DLY_W-1:0]   delay;
   logic [TW-1:0]      times [PLAYERS];
   logic [PLAYERS-1:0] hit;
   logic [PLAYERS-1:0] sat;
   logic [PLAYERS-1:0] stopped;
   logic               round_start;
   logic               enter_res;
   logic               res_ph1;
   logic               res_ph2;
   logic [1:0]         win_idx;
   logic               win_ok;
   logic [TW-1:0]      win_t;

   // One-step decimal increment; callers never pass an all-9s value.
   function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] v);
      logic [TW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (v[4*d +: 4] == 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = v[4*d +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign start_rise  = START & ~start_q;
   assign btn_rise    = BTN & ~btn_q;
   assign tick        = (tick_cnt == CNT_W'(TICK_DIV - 1));
   assign round_start = start_rise && (state == S_IDLE || state == S_RESULT);
   assign enter_res   = (state_n == S_RESULT) && (state != S_RESULT);

   for (genvar g = 0; g < PLAYERS; g++) begin : g_pack
      assign TIME_BCD[TW*g +: TW] = times[g];
   end

   // A player is stopped once pressed, fouled, or saturated (timeout).
   always_comb begin
      for (int p = 0; p < PLAYERS; p++) begin
         sat[p]     = (times[p] == ALL9);
         stopped[p] = hit[p] | FOUL[p] | sat[p];
      end
   end

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      win_ok  = 1'b0;
      win_idx = 2'd0;
      win_t   = ALL9;
      for (int p = 0; p < PLAYERS; p++) begin
         if (hit[p] && !FOUL[p] && (!win_ok || times[p] < win_t)) begin
            win_ok  = 1'b1;
            win_idx = 2'(p);
            win_t   = times[p];
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      LED     = 1'b0;
      DONE    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_rise) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (tick && delay == '0)
               state_n = (&(FOUL | btn_rise)) ? S_RESULT : S_ARMED;
         end
         S_ARMED: begin
            LED = 1'b1;
            if (&stopped) state_n = S_RESULT;
         end
         S_RESULT: begin
            DONE = 1'b1;
            if (start_rise) state_n = S_WAIT;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         lfsr      <= 11'h001;
         start_q   <= 1'b0;
         btn_q     <= '0;
         tick_cnt  <= '0;
         delay     <= '0;
         FOUL      <= '0;
         hit       <= '0;
         WINNER    <= 2'd0;
         WIN_VALID <= 1'b0;
         BEST_BCD  <= ALL9;
         BEST_ID   <= 2'd0;
         res_ph1   <= 1'b0;
         res_ph2   <= 1'b0;
         // NOTE: the time array is a handful of flops, not a RAM, so it is reset like any other register.
         for (int p = 0; p < PLAYERS; p++) times[p] <= '0;
      end else begin
         lfsr     <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
         start_q  <= START;
         btn_q    <= BTN;
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         res_ph1  <= enter_res;
         res_ph2  <= res_ph1;

         if (round_start) begin
            tick_cnt  <= '0;
            delay     <= DLY_W'(MIN_DELAY) + DLY_W'(lfsr);
            FOUL      <= '0;
            hit       <= '0;
            WIN_VALID <= 1'b0;
            res_ph1   <= 1'b0;
            res_ph2   <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) times[p] <= '0;
         end else begin
            case (state)
               S_WAIT: begin
                  if (tick && delay != '0) delay <= delay - DLY_W'(1);
                  for (int p = 0; p < PLAYERS; p++) begin
                     if (btn_rise[p]) begin
                        FOUL[p]  <= 1'b1;
                        times[p] <= ALL9;
                     end
                  end
               end
               S_ARMED: begin
                  // A press on a tick edge latches the pre-increment time.
                  for (int p = 0; p < PLAYERS; p++) begin
                     if (!stopped[p]) begin
                        if (btn_rise[p])  hit[p]   <= 1'b1;
                        else if (tick)    times[p] <= bcd_inc(times[p]);
                     end
                  end
               end
               S_RESULT: begin
                  if (res_ph1) begin
                     WINNER    <= win_idx;
                     WIN_VALID <= win_ok;
                  end
                  if (res_ph2 && win_ok && win_t < BEST_BCD) begin
                     BEST_BCD <= win_t;
                     BEST_ID  <= win_idx;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
